// File: rtl/disp_scan_ctrl.sv
// Two-digit seven-segment scan controller: latches a 4-bit value, converts it to
// BCD with a shift-add-3 engine and multiplexes tens/units onto shared segments.
module disp_scan_ctrl #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] s,
    input  logic       load,
    output logic       busy,
    output logic [3:0] digit,
    output logic       an0,
    output logic       an1
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST_C  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

    typedef enum logic {C_IDLE, C_SHIFT} conv_t;
    typedef enum logic {S_UNITS, S_TENS} slot_t;

    conv_t       r_cstate, w_cstate_nxt;
    slot_t       r_slot, w_slot_nxt;
    logic [1:0]  r_step;
    logic [3:0]  r_sh, r_bcd_t, r_bcd_u;
    logic [3:0]  r_tens, r_units;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic        w_start, w_commit, w_wrap;
    logic [3:0]  w_u_adj;
    logic [11:0] w_shifted;
    logic [3:0]  w_tens_nxt, w_units_nxt, w_digit_nxt;
    logic        w_an0_nxt, w_an1_nxt;
    logic        r_an0, r_an1;
    logic [3:0]  r_digit;

    // ---------------- conversion FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_cstate <= C_IDLE;
        else     r_cstate <= w_cstate_nxt;
    end

    always_comb begin
        w_cstate_nxt = r_cstate;
        case (r_cstate)
            C_IDLE:  if (load)           w_cstate_nxt = C_SHIFT;
            C_SHIFT: if (r_step == 2'd3) w_cstate_nxt = C_IDLE;
            default:                     w_cstate_nxt = C_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_cstate == C_SHIFT);
        w_start  = (r_cstate == C_IDLE) && load;
        w_commit = (r_cstate == C_SHIFT) && (r_step == 2'd3);
    end

    // One shift-add-3 step; tens never reaches 5 for a 4-bit input.
    assign w_u_adj   = (r_bcd_u >= 4'd5) ? r_bcd_u + 4'd3 : r_bcd_u;
    assign w_shifted = {r_bcd_t[2:0], w_u_adj, r_sh, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_step  <= 2'd0;
            r_sh    <= 4'd0;
            r_bcd_t <= 4'd0;
            r_bcd_u <= 4'd0;
            r_tens  <= 4'd0;
            r_units <= 4'd0;
        end else begin
            if (w_start) begin
                r_sh    <= s;
                r_bcd_t <= 4'd0;
                r_bcd_u <= 4'd0;
                r_step  <= 2'd0;
            end else if (busy) begin
                r_bcd_t <= w_shifted[11:8];
                r_bcd_u <= w_shifted[7:4];
                r_sh    <= w_shifted[3:0];
                r_step  <= r_step + 2'd1;
            end
            // Final step lands straight in the display pair so both digits flip together.
            if (w_commit) begin
                r_tens  <= w_shifted[11:8];
                r_units <= w_shifted[7:4];
            end
        end
    end

    // ---------------- scan FSM ----------------
    assign w_wrap    = (r_cnt == LAST_C);
    assign w_cnt_nxt = w_wrap ? '0 : r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= S_UNITS;
            r_cnt  <= '0;
        end else begin
            r_slot <= w_slot_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_slot_nxt = r_slot;
        if (w_wrap) w_slot_nxt = (r_slot == S_UNITS) ? S_TENS : S_UNITS;
    end

    // Outputs are registered from next-state values, so they track state with no lag.
    always_comb begin
        w_tens_nxt  = w_commit ? w_shifted[11:8] : r_tens;
        w_units_nxt = w_commit ? w_shifted[7:4]  : r_units;
        w_digit_nxt = (w_slot_nxt == S_TENS) ? w_tens_nxt : w_units_nxt;
        w_an0_nxt   = !((w_slot_nxt == S_UNITS) && (w_cnt_nxt >= GUARD_C));
        w_an1_nxt   = !((w_slot_nxt == S_TENS) && (w_cnt_nxt >= GUARD_C) &&
                        !(BLANK_LZ && (w_tens_nxt == 4'd0)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_digit <= 4'd0;
            r_an0   <= 1'b1;
            r_an1   <= 1'b1;
        end else begin
            r_digit <= w_digit_nxt;
            r_an0   <= w_an0_nxt;
            r_an1   <= w_an1_nxt;
        end
    end

    assign digit = r_digit;
    assign an0   = r_an0;
    assign an1   = r_an1;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: a blanking and a non-blanking instance share stimulus
// and are compared every cycle against a decimal/time-based reference model.
module tb_disp_scan_ctrl;

    localparam int RD = 8;
    localparam int G  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] s = 4'd0;
    logic       load = 1'b0;
    logic       busy, an0, an1, busy_nb, an0_nb, an1_nb;
    logic [3:0] digit, digit_nb;
    logic [6:0] obs, obs_nb;

    int n_chk = 0;
    int n_pass = 0;

    // reference model state
    int m_t = 0, m_bc = 0, m_val = 0, m_tens = 0, m_units = 0;

    always #5 clk = ~clk;

    disp_scan_ctrl #(.REFRESH_DIV(RD), .GUARD(G), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .s(s), .load(load),
        .busy(busy), .digit(digit), .an0(an0), .an1(an1));

    disp_scan_ctrl #(.REFRESH_DIV(RD), .GUARD(G), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .s(s), .load(load),
        .busy(busy_nb), .digit(digit_nb), .an0(an0_nb), .an1(an1_nb));

    assign obs    = {busy, digit, an1, an0};
    assign obs_nb = {busy_nb, digit_nb, an1_nb, an0_nb};

    // Model: conversion is a 4-cycle countdown ending in decimal split; scan is
    // derived from elapsed cycles since reset.
    always @(posedge clk) begin
        if (rst) begin
            m_t = 0; m_bc = 0; m_tens = 0; m_units = 0;
        end else begin
            m_t++;
            if (m_bc > 0) begin
                m_bc--;
                if (m_bc == 0) begin
                    m_tens  = m_val / 10;
                    m_units = m_val % 10;
                end
            end else if (load) begin
                m_bc  = 4;
                m_val = int'(s);
            end
        end
    end

    function automatic logic [6:0] exp_out(input bit bl);
        int slot, pos;
        logic a0, a1;
        slot = (m_t / RD) % 2;
        pos  = m_t % RD;
        a0 = !(slot == 0 && pos >= G);
        a1 = !(slot == 1 && pos >= G && !(bl && m_tens == 0));
        return {m_bc != 0, (slot == 1) ? 4'(m_tens) : 4'(m_units), a1, a0};
    endfunction

    task automatic test_reset();
        rst = 1'b1; load = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (obs !== 7'b0_0000_11) $display("FAIL reset_vals got %b exp %b", obs, 7'b0_0000_11);
        else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 2 * RD; i++) begin
            @(negedge clk);
            n_chk++;
            if (obs !== exp_out(1)) $display("FAIL reset_scan cyc %0d got %b exp %b", i, obs, exp_out(1));
            else n_pass++;
            n_chk++;
            if (obs_nb !== exp_out(0)) $display("FAIL reset_scan_nb cyc %0d got %b exp %b", i, obs_nb, exp_out(0));
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        int bcnt = 0;
        s = 4'd13; load = 1'b1;
        for (int i = 0; i < 3 * RD; i++) begin
            @(negedge clk);
            load = 1'b0;
            if (busy) bcnt++;
            n_chk++;
            if (obs !== exp_out(1)) $display("FAIL basic13 cyc %0d got %b exp %b", i, obs, exp_out(1));
            else n_pass++;
        end
        n_chk++;
        if (bcnt !== 4) $display("FAIL busy_len got %0d exp 4", bcnt);
        else n_pass++;
    endtask

    task automatic test_load_busy();
        for (int i = 0; i < 3 * RD; i++) begin
            load = (i == 0 || i == 2 || i == 6);
            s    = (i == 0) ? 4'd12 : 4'd9;
            @(negedge clk);
            n_chk++;
            if (obs !== exp_out(1)) $display("FAIL load_busy cyc %0d got %b exp %b", i, obs, exp_out(1));
            else n_pass++;
            n_chk++;
            if (obs_nb !== exp_out(0)) $display("FAIL load_busy_nb cyc %0d got %b exp %b", i, obs_nb, exp_out(0));
            else n_pass++;
            if (i == 4) begin
                n_chk++;
                if ({m_tens, m_units} != {32'd1, 32'd2} || {digit == 4'd1 || digit == 4'd2} !== 1'b1)
                    $display("FAIL drop_load got digit %0d exp 1 or 2", digit);
                else n_pass++;
            end
        end
        load = 1'b0;
    endtask

    task automatic test_noblank();
        s = 4'd5; load = 1'b1;
        for (int i = 0; i < 3 * RD; i++) begin
            @(negedge clk);
            load = 1'b0;
            n_chk++;
            if (obs_nb !== exp_out(0)) $display("FAIL noblank cyc %0d got %b exp %b", i, obs_nb, exp_out(0));
            else n_pass++;
            n_chk++;
            if (obs !== exp_out(1)) $display("FAIL blank5 cyc %0d got %b exp %b", i, obs, exp_out(1));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        s = 4'd7; load = 1'b1;
        repeat (6) begin @(negedge clk); load = 1'b0; end
        s = 4'd15; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_chk++;
        if (obs !== 7'b0_0000_11) $display("FAIL reset_mid got %b exp %b", obs, 7'b0_0000_11);
        else n_pass++;
        for (int i = 0; i < 2 * RD; i++) begin
            @(negedge clk);
            n_chk++;
            if (obs !== exp_out(1) || digit !== 4'd0)
                $display("FAIL reset_mid_after cyc %0d got %b exp %b", i, obs, exp_out(1));
            else n_pass++;
        end
    endtask

    task automatic test_atomic();
        bit sent = 0;
        s = 4'd9; load = 1'b1;
        repeat (6) begin @(negedge clk); load = 1'b0; end
        s = 4'd15;
        for (int i = 0; i < 4 * RD; i++) begin
            load = !sent && (m_bc == 0) && ((m_t + 5) % RD == 0);
            if (load) sent = 1;
            @(negedge clk);
            n_chk++;
            if (obs !== exp_out(1)) $display("FAIL atomic cyc %0d got %b exp %b", i, obs, exp_out(1));
            else n_pass++;
        end
        load = 1'b0;
        n_chk++;
        if (!sent || m_tens != 1 || m_units != 5) $display("FAIL atomic_sent got %0d%0d exp 15", m_tens, m_units);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            load = ($urandom_range(0, 3) == 0);
            s    = 4'($urandom_range(0, 15));
            rst  = ($urandom_range(0, 149) == 0);
            @(negedge clk);
            n_chk++;
            if (obs !== exp_out(1)) $display("FAIL random cyc %0d got %b exp %b", i, obs, exp_out(1));
            else n_pass++;
            n_chk++;
            if (obs_nb !== exp_out(0)) $display("FAIL random_nb cyc %0d got %b exp %b", i, obs_nb, exp_out(0));
            else n_pass++;
        end
        load = 1'b0; rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_load_busy();
        test_noblank();
        test_reset_mid();
        test_atomic();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
